// File: rtl/sm_pkg.sv
// rtl/sm_pkg.sv - shared widths, mem_wen op codes and entry layout for the SM stage
package sm_pkg;

    localparam int NODE_W    = 16;
    localparam int GEN_W     = 12;
    localparam int SM_DATA_W = 32;

    // FC1 memory op encoding carried on mem_wen
    localparam logic [1:0] MW_PASS  = 2'b00;
    localparam logic [1:0] MW_STORE = 2'b01;
    localparam logic [1:0] MW_MATCH = 2'b10;
    localparam logic [1:0] MW_RSVD  = 2'b11;

    // Full waiting-operand entry as seen by software/debug views
    typedef struct packed {
        logic                 valid;
        logic [NODE_W-1:0]    node;
        logic [GEN_W-1:0]     gen;
        logic [SM_DATA_W-1:0] data;
    } sm_entry_t;

    // Tag part of an entry, used for match/lookup compares
    typedef struct packed {
        logic              valid;
        logic [NODE_W-1:0] node;
        logic [GEN_W-1:0]  gen;
    } sm_tag_t;

    function automatic logic tag_eq(input sm_tag_t t,
                                    input logic [NODE_W-1:0] node,
                                    input logic [GEN_W-1:0] gen);
        return t.valid && (t.node == node) && (t.gen == gen);
    endfunction

endpackage

// File: rtl/sm_tag_ram.sv
// rtl/sm_tag_ram.sv - waiting-operand store: flop valid bits, one write port, one registered read port
module sm_tag_ram
    import sm_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // write port: set stores a new entry, clr invalidates one
    input  logic              wr_set_i,
    input  logic              wr_clr_i,
    input  logic [ADDR_W-1:0] wr_idx_i,
    input  logic [15:0]       wr_node_i,
    input  logic [11:0]       wr_gen_i,
    input  logic [DATA_W-1:0] wr_data_i,
    // combinational view of the write-side entry, for op decode in the same cycle
    input  logic [ADDR_W-1:0] pk_idx_i,
    output logic              pk_valid_o,
    output logic [15:0]       pk_node_o,
    output logic [11:0]       pk_gen_o,
    // registered read port, sampled on the edge where rd_en_i is high
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_idx_i,
    output logic              rd_valid_o,
    output logic [15:0]       rd_node_o,
    output logic [11:0]       rd_gen_o,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0]  valid_q;
    logic [15:0]       node_mem [DEPTH];
    logic [11:0]       gen_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic              rd_valid_q;
    logic [15:0]       rd_node_q;
    logic [11:0]       rd_gen_q;
    logic [DATA_W-1:0] rd_data_q;

    // Valid bits live in flops so reset can clear every entry in one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_set_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end else if (wr_clr_i) begin
            valid_q[wr_idx_i] <= 1'b0;
        end
    end

    // Payload is only meaningful under its valid bit, so it carries no reset
    always_ff @(posedge clk) begin
        if (wr_set_i) begin
            node_mem[wr_idx_i] <= wr_node_i;
            gen_mem[wr_idx_i]  <= wr_gen_i;
            data_mem[wr_idx_i] <= wr_data_i;
        end
    end

    // Registered read sees the pre-write contents of a same-cycle write
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_node_q  <= '0;
            rd_gen_q   <= '0;
            rd_data_q  <= '0;
        end else if (rd_en_i) begin
            rd_valid_q <= valid_q[rd_idx_i];
            rd_node_q  <= node_mem[rd_idx_i];
            rd_gen_q   <= gen_mem[rd_idx_i];
            rd_data_q  <= data_mem[rd_idx_i];
        end
    end

    assign pk_valid_o = valid_q[pk_idx_i];
    assign pk_node_o  = node_mem[pk_idx_i];
    assign pk_gen_o   = gen_mem[pk_idx_i];

    assign rd_valid_o = rd_valid_q;
    assign rd_node_o  = rd_node_q;
    assign rd_gen_o   = rd_gen_q;
    assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/sm_match_store.sv
// rtl/sm_match_store.sv - SM matching-memory stage top; optional SM_LKUP_BYPASS_EN gives post-write lookups
module sm_match_store
    import sm_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       node_i,
    input  logic [11:0]       gen_i,
    input  logic [DATA_W-1:0] opr0_i,
    input  logic [DATA_W-1:0] opr1_i,
    input  logic [1:0]        mem_wen_i,
    input  logic              lkup_req_i,
    input  logic [15:0]       lkup_node_i,
    input  logic [11:0]       lkup_gen_i,
    output logic              lkup_vld_o,
    output logic              lkup_hit_o,
    output logic [DATA_W-1:0] lkup_data_o,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       node_o,
    output logic [11:0]       gen_o,
    output logic [DATA_W-1:0] opr0_o,
    output logic [DATA_W-1:0] opr1_o,
    output logic              err_o
);

    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] lk_idx;
    logic              pk_valid;
    logic [15:0]       pk_node;
    logic [11:0]       pk_gen;
    logic              rd_valid;
    logic [15:0]       rd_node;
    logic [11:0]       rd_gen;
    logic [DATA_W-1:0] rd_data;

    logic              xfer;
    logic              entry_hit;
    logic              store_ok;
    logic              store_err;
    logic              match_ok;
    logic              match_err;
    logic              rsvd_err;
    logic              fire;

    logic              out_valid_q, out_valid_d;
    logic [15:0]       node_q, node_d;
    logic [11:0]       gen_q, gen_d;
    logic [DATA_W-1:0] opr0_q, opr0_d;
    logic [DATA_W-1:0] opr1_q, opr1_d;
    logic              err_q, err_d;

    logic              lkup_vld_q;
    logic [15:0]       lk_node_q;
    logic [11:0]       lk_gen_q;
    logic              hit_raw;
    logic [DATA_W-1:0] data_raw;

    assign wr_idx = node_i[ADDR_W-1:0];
    assign lk_idx = lkup_node_i[ADDR_W-1:0];

    // Output slot frees up when empty or draining this cycle; STORE obeys it too
    assign in_ready  = ~out_valid_q | out_ready;
    assign xfer      = in_valid & in_ready;
    assign entry_hit = tag_eq('{valid: pk_valid, node: pk_node, gen: pk_gen}, node_i, gen_i);

    assign store_ok  = xfer & (mem_wen_i == MW_STORE) & ~pk_valid;
    assign store_err = xfer & (mem_wen_i == MW_STORE) &  pk_valid;
    assign match_ok  = xfer & (mem_wen_i == MW_MATCH) &  entry_hit;
    assign match_err = xfer & (mem_wen_i == MW_MATCH) & ~entry_hit;
    assign rsvd_err  = xfer & (mem_wen_i == MW_RSVD);
    // A mismatched MATCH still fires so the pipeline never loses a token
    assign fire      = xfer & ((mem_wen_i == MW_PASS) | (mem_wen_i == MW_MATCH));

    sm_tag_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk        (clk),
        .rst        (rst),
        .wr_set_i   (store_ok),
        .wr_clr_i   (match_ok),
        .wr_idx_i   (wr_idx),
        .wr_node_i  (node_i),
        .wr_gen_i   (gen_i),
        .wr_data_i  (opr0_i),
        .pk_idx_i   (wr_idx),
        .pk_valid_o (pk_valid),
        .pk_node_o  (pk_node),
        .pk_gen_o   (pk_gen),
        .rd_en_i    (lkup_req_i),
        .rd_idx_i   (lk_idx),
        .rd_valid_o (rd_valid),
        .rd_node_o  (rd_node),
        .rd_gen_o   (rd_gen),
        .rd_data_o  (rd_data)
    );

    // Next state of the fired-packet register and the sticky error flag
    always_comb begin
        out_valid_d = out_valid_q;
        node_d      = node_q;
        gen_d       = gen_q;
        opr0_d      = opr0_q;
        opr1_d      = opr1_q;
        err_d       = err_q | store_err | match_err | rsvd_err;
        if (fire) begin
            out_valid_d = 1'b1;
            node_d      = node_i;
            gen_d       = gen_i;
            opr0_d      = opr0_i;
            opr1_d      = opr1_i;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register and error flag; reset discards any pending packet
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            node_q      <= '0;
            gen_q       <= '0;
            opr0_q      <= '0;
            opr1_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            node_q      <= node_d;
            gen_q       <= gen_d;
            opr0_q      <= opr0_d;
            opr1_q      <= opr1_d;
            err_q       <= err_d;
        end
    end

    // Capture the lookup tag alongside the RAM read so the compare lines up
    always_ff @(posedge clk) begin
        if (rst) begin
            lkup_vld_q <= 1'b0;
            lk_node_q  <= '0;
            lk_gen_q   <= '0;
        end else begin
            lkup_vld_q <= lkup_req_i;
            if (lkup_req_i) begin
                lk_node_q <= lkup_node_i;
                lk_gen_q  <= lkup_gen_i;
            end
        end
    end

`ifdef SM_LKUP_BYPASS_EN
    logic              byp_q, byp_d;
    logic              byp_hit_q, byp_hit_d;
    logic [DATA_W-1:0] byp_data_q, byp_data_d;

    // A lookup colliding with an effective write reports the post-write entry
    always_comb begin
        byp_d      = 1'b0;
        byp_hit_d  = 1'b0;
        byp_data_d = '0;
        if (lkup_req_i && (lk_idx == wr_idx) && (store_ok || match_ok)) begin
            byp_d = 1'b1;
            if (store_ok && (lkup_node_i == node_i) && (lkup_gen_i == gen_i)) begin
                byp_hit_d  = 1'b1;
                byp_data_d = opr0_i;
            end
        end
    end

    // Bypass result registered to align with the RAM read
    always_ff @(posedge clk) begin
        if (rst) begin
            byp_q      <= 1'b0;
            byp_hit_q  <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_q      <= byp_d;
            byp_hit_q  <= byp_hit_d;
            byp_data_q <= byp_data_d;
        end
    end

    assign hit_raw  = byp_q ? byp_hit_q  : (rd_valid && (rd_node == lk_node_q) && (rd_gen == lk_gen_q));
    assign data_raw = byp_q ? byp_data_q : rd_data;
`else
    assign hit_raw  = rd_valid && (rd_node == lk_node_q) && (rd_gen == lk_gen_q);
    assign data_raw = rd_data;
`endif

    assign lkup_vld_o  = lkup_vld_q;
    assign lkup_hit_o  = lkup_vld_q & hit_raw;
    assign lkup_data_o = lkup_hit_o ? data_raw : '0;

    assign out_valid = out_valid_q;
    assign node_o    = node_q;
    assign gen_o     = gen_q;
    assign opr0_o    = opr0_q;
    assign opr1_o    = opr1_q;
    assign err_o     = err_q;

endmodule
